// File: rtl/led_owner_arbiter.sv
// LED bank owner arbiter: round-robin req/gnt ownership with lease preemption
// and a heartbeat on the bank whenever nobody owns it.
module led_owner_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int LED_W         = 8,
  parameter int MAX_LEASE_CYC = 125_000_000,
  parameter int HB_DIV        = 62_500_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   led_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy,
  output logic                       timeout,
  output logic [LED_W-1:0]           leds_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HBW = $clog2(HB_DIV);
  localparam int LW  = (MAX_LEASE_CYC > 0) ? $clog2(MAX_LEASE_CYC + 1) : 1;
  localparam logic [LW-1:0]  LEASE_MAX  = LW'(MAX_LEASE_CYC);
  localparam logic [LW-1:0]  LEASE_LAST =
    (MAX_LEASE_CYC > 0) ? LW'(MAX_LEASE_CYC - 1) : '0;
  localparam logic [HBW-1:0] HB_LAST = HBW'(HB_DIV - 1);

  typedef enum logic [1:0] {IDLE, OWN, EVICT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] lock;
  logic [HBW-1:0]     hb_cnt;
  logic               hb, hb_nxt;
  logic [LW-1:0]      lease_cnt;

  logic [NUM_REQ-1:0] elig, own_oh, gnt_d;
  logic [LED_W-1:0]   own_data, hb_led, leds_d;
  logic [IDW-1:0]     win, owner_d;
  logic               found, grant, expired;

  assign hb_nxt = (hb_cnt == HB_LAST) ? ~hb : hb;
  assign hb_led = LED_W'(hb_nxt);
  assign elig   = req & ~lock;
  assign expired = (MAX_LEASE_CYC != 0) && (lease_cnt >= LEASE_LAST);

  always_comb begin
    own_oh   = '0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_id == IDW'(i)) begin
        own_oh[i] = 1'b1;
        own_data  = led_data[i*LED_W +: LED_W];
      end
    end
  end

  // Round-robin: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    leds_d  = leds_o;
    unique case (state_q)
      IDLE: begin
        leds_d = hb_led;
        if (found) begin
          state_d = OWN;
          grant   = 1'b1;
        end
      end
      OWN: begin
        if (!req[owner_id]) begin
          state_d = IDLE;
          leds_d  = hb_led;
        end else begin
          leds_d = own_data;
          if (expired && |(elig & ~own_oh))
            state_d = EVICT;
        end
      end
      default: state_d = IDLE;
    endcase
    owner_d = grant ? win : owner_id;
    gnt_d   = '0;
    if (state_d == OWN)
      gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      lock      <= '0;
      hb_cnt    <= '0;
      hb        <= 1'b0;
      lease_cnt <= '0;
      owner_id  <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      leds_o    <= '0;
    end else begin
      state_q  <= state_d;
      hb       <= hb_nxt;
      hb_cnt   <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + 1'b1;
      gnt      <= gnt_d;
      busy     <= (state_d == OWN);
      timeout  <= (state_d == EVICT);
      leds_o   <= leds_d;
      owner_id <= owner_d;
      if (grant) begin
        rr_ptr    <= IDW'((int'(win) + 1) % NUM_REQ);
        lease_cnt <= '0;
      end else if (state_q == OWN && lease_cnt != LEASE_MAX) begin
        lease_cnt <= lease_cnt + 1'b1;
      end
      // Dropping req always unlocks, even during the eviction cycle.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i])
          lock[i] <= 1'b0;
        else if (state_q == EVICT && own_oh[i])
          lock[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_owner_arbiter.sv
// Directed and randomized checks of led_owner_arbiter against a
// cycle-level ownership model.
module tb_led_owner_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int MAX = 16;
  localparam int HB  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] led_data;
  logic [N-1:0]   gnt;
  logic [1:0]     owner_id;
  logic           busy;
  logic           timeout;
  logic [W-1:0]   leds_o;

  led_owner_arbiter #(
    .NUM_REQ(N), .LED_W(W), .MAX_LEASE_CYC(MAX), .HB_DIV(HB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .led_data(led_data),
    .gnt(gnt), .owner_id(owner_id), .busy(busy),
    .timeout(timeout), .leds_o(leds_o)
  );

  always #5 clk = ~clk;

  int         vecs = 0;
  int         miss = 0;
  int         m_mode, m_owner, m_ptr, m_held, m_cyc;
  logic [N-1:0] m_lock;
  logic [W-1:0] m_leds;
  int         d_order[$];
  logic [N-1:0] prev_gnt;
  logic       saw_tmo;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_owner = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_cyc   = 0;
    m_lock  = '0;
    m_leds  = '0;
  endtask

  // mode: 0 unowned, 1 owned, 2 eviction cycle
  task automatic model_step();
    int           w;
    logic         hbv;
    logic [N-1:0] nl;
    logic         waiting;
    w = -1;
    m_cyc++;
    hbv = ((m_cyc / HB) % 2) == 1;
    for (int i = 0; i < N; i++)
      nl[i] = req[i] && (m_lock[i] || (m_mode == 2 && m_owner == i));
    case (m_mode)
      0: begin
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N] && !m_lock[(m_ptr + k) % N])
            w = (m_ptr + k) % N;
        m_leds = W'(hbv);
        if (w >= 0) begin
          m_mode  = 1;
          m_owner = w;
          m_ptr   = (w + 1) % N;
          m_held  = 0;
        end
      end
      1: begin
        m_held++;
        if (!req[m_owner]) begin
          m_mode = 0;
          m_leds = W'(hbv);
        end else begin
          m_leds  = led_data[m_owner*W +: W];
          waiting = |(req & ~m_lock & ~(N'(1) << m_owner));
          if (m_held >= MAX && waiting)
            m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
    m_lock = nl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("gnt", 32'(gnt), m_mode == 1 ? 32'(1) << m_owner : 32'd0);
    check("owner_id", 32'(owner_id), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_mode == 1));
    check("timeout", 32'(timeout), 32'(m_mode == 2));
    check("leds_o", 32'(leds_o), 32'(m_leds));
    if (gnt != '0 && prev_gnt == '0)
      d_order.push_back(int'(owner_id));
    prev_gnt = gnt;
    saw_tmo  = saw_tmo | timeout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_gnt = '0;
    saw_tmo  = 1'b0;
    d_order.delete();
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    req      = '0;
    led_data = '0;
    prev_gnt = '0;
    saw_tmo  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_leds", 32'(leds_o), 0);
    check("rst_owner", 32'(owner_id), 0);
    rst = 1'b0;
    model_reset();

    // idle heartbeat
    for (int i = 0; i < 12; i++) tick();

    // single owner
    led_data[7:0] = 8'hA5;
    req = 4'b0001;
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    tick();
    check("single_leds", 32'(leds_o), 32'hA5);
    for (int i = 0; i < 3; i++) tick();
    req = 4'b0000;
    tick();
    check("release_gnt", 32'(gnt), 0);
    for (int i = 0; i < 6; i++) tick();

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 40; i++) begin
      req = 4'hF;
      if (m_mode == 1 && m_held >= 3) req[m_owner] = 1'b0;
      tick();
    end
    check("rr_count", 32'(d_order.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < d_order.size())
        check("rr_order", 32'(d_order[k]), 32'(k % 4));

    // preemption
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0101;
    n = 0;
    while (gnt === 4'b0001 && n < 40) begin
      n++;
      tick();
    end
    check("lease_len", 32'(n), 32'(MAX));
    check("evict_tmo", 32'(timeout), 1);
    check("evict_gnt", 32'(gnt), 0);
    tick();
    tick();
    check("new_owner", 32'(gnt), 32'b0100);
    saw_tmo = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("locked_no_tmo", 32'(saw_tmo), 0);
    req = 4'b0100;
    tick();
    req = 4'b0101;
    for (int i = 0; i < 20; i++) tick();
    check("unlock_tmo", 32'(saw_tmo), 1);

    // no contention past lease
    do_reset();
    req = 4'b0010;
    tick();
    for (int i = 0; i < 40; i++) tick();
    check("solo_gnt", 32'(gnt), 32'b0010);
    check("solo_no_tmo", 32'(saw_tmo), 0);

    // async reset while owning
    do_reset();
    led_data[7:0] = 8'h3C;
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_leds", 32'(leds_o), 32'h3C);
    #2 rst = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 0);
    check("async_leds", 32'(leds_o), 0);
    check("async_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    prev_gnt = '0;
    req = 4'b1100;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'b0100);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      led_data = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
